// File: rtl/alu_seq_pkg.sv
// Shared constants and types for the byte-ALU micro-program sequencer.
// Covers ALU opcodes, sequencer ops, status bit positions and the sequencer state enum.
package alu_seq_pkg;

    localparam logic [3:0] ALU_NOP    = 4'h0;
    localparam logic [3:0] ALU_LOAD   = 4'h1;
    localparam logic [3:0] ALU_ADD    = 4'h2;
    localparam logic [3:0] ALU_SUB    = 4'h3;
    localparam logic [3:0] ALU_ZERO   = 4'h4;
    localparam logic [3:0] ALU_ONE    = 4'h5;
    localparam logic [3:0] ALU_XOR    = 4'h6;
    localparam logic [3:0] ALU_NOT    = 4'h7;
    localparam logic [3:0] ALU_SHL    = 4'h8;
    localparam logic [3:0] ALU_SHR    = 4'h9;
    localparam logic [3:0] ALU_STATUS = 4'hF;

    localparam logic [3:0] OP_BZ   = 4'hA;
    localparam logic [3:0] OP_BNZ  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hD;
    localparam logic [3:0] OP_BC   = 4'hE;
    localparam logic [3:0] OP_RSVD = 4'hF;

    localparam int STAT_Z = 0;
    localparam int STAT_N = 1;
    localparam int STAT_C = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_EVAL,
        ST_DONE
    } seq_state_e;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op <= ALU_SHR);
    endfunction

endpackage

// File: rtl/alu_seq_prog_mem.sv
// Program store for the sequencer: DEPTH x 12-bit words, one synchronous write port
// and one asynchronous read port. Contents are not touched by reset.
module alu_seq_prog_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [11:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [11:0]   rdata
);

    logic [11:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/alu_sequencer.sv
// Micro-program sequencer for the byte ALU: fetches {op,imm} words, issues ALU ops one
// per cycle, evaluates ALU status for branches and captures the accumulator on HALT.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int MAX_STEPS = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [11:0]              prog_wdata,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [7:0]               result,
    output logic [3:0]               alu_opcode,
    output logic [7:0]               alu_data,
    input  logic [7:0]               alu_data_out
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [7:0] STEP_LIMIT = 8'(MAX_STEPS - 1);

    seq_state_e    state, state_nxt;
    logic [AW-1:0] pc, pc_nxt;
    logic [7:0]    steps, steps_nxt;
    logic          err_nxt;
    logic [7:0]    result_nxt;
    logic [11:0]   word;
    logic [3:0]    op;
    logic [7:0]    imm;
    logic          taken;

    alu_seq_prog_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_prog_mem (
        .clk   (clk),
        .we    (prog_we && (state == ST_IDLE)),
        .waddr (prog_addr),
        .wdata (prog_wdata),
        .raddr (pc),
        .rdata (word)
    );

    assign op  = word[11:8];
    assign imm = word[7:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            pc     <= '0;
            steps  <= '0;
            err    <= 1'b0;
            result <= '0;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            steps  <= steps_nxt;
            err    <= err_nxt;
            result <= result_nxt;
        end
    end

    // In EVAL the branch word is still at mem[pc] and alu_data_out carries ALU status.
    always_comb begin
        taken = 1'b0;
        case (op)
            OP_BZ:   taken = alu_data_out[STAT_Z];
            OP_BNZ:  taken = !alu_data_out[STAT_Z];
            OP_BC:   taken = alu_data_out[STAT_C];
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        steps_nxt  = steps;
        err_nxt    = err;
        result_nxt = result;
        alu_opcode = ALU_NOP;
        alu_data   = '0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    pc_nxt    = '0;
                    steps_nxt = '0;
                    err_nxt   = 1'b0;
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                steps_nxt = steps + 8'd1;
                if ((steps == STEP_LIMIT) && (op != OP_HALT)) begin
                    // Watchdog abort: the pending instruction is dropped, not issued.
                    result_nxt = alu_data_out;
                    err_nxt    = 1'b1;
                    state_nxt  = ST_DONE;
                end else if (is_alu_op(op)) begin
                    alu_opcode = op;
                    alu_data   = imm;
                    pc_nxt     = pc + AW'(1);
                end else begin
                    case (op)
                        OP_BZ, OP_BNZ, OP_BC: begin
                            alu_opcode = ALU_STATUS;
                            state_nxt  = ST_EVAL;
                        end
                        OP_JMP:  pc_nxt = imm[AW-1:0];
                        OP_HALT: begin
                            result_nxt = alu_data_out;
                            state_nxt  = ST_DONE;
                        end
                        default: pc_nxt = pc + AW'(1);
                    endcase
                end
            end
            ST_EVAL: begin
                pc_nxt    = taken ? imm[AW-1:0] : pc + AW'(1);
                state_nxt = ST_EXEC;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural byte ALU and a result scoreboard.
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       prog_we = 1'b0;
    logic [3:0] prog_addr = '0;
    logic [11:0] prog_wdata = '0;
    logic       start = 1'b0;
    logic       busy, done, err;
    logic [7:0] result, alu_data, alu_data_out;
    logic [3:0] alu_opcode;
    logic       rst_n;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] res;
        logic       err;
        int         lat;
        string      tag;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    assign rst_n = ~rst;

    alu_sequencer #(.DEPTH(16), .MAX_STEPS(255)) dut (
        .clk          (clk),
        .rst          (rst),
        .prog_we      (prog_we),
        .prog_addr    (prog_addr),
        .prog_wdata   (prog_wdata),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .result       (result),
        .alu_opcode   (alu_opcode),
        .alu_data     (alu_data),
        .alu_data_out (alu_data_out)
    );

    // Behavioural byte ALU: registered accumulator, status visible after a STATUS op.
    logic [7:0] acc;
    logic       cy;
    logic [3:0] prev_op;
    logic [7:0] status;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc     <= '0;
            cy      <= 1'b0;
            prev_op <= ALU_NOP;
        end else begin
            prev_op <= alu_opcode;
            case (alu_opcode)
                ALU_LOAD: acc <= alu_data;
                ALU_ADD:  {cy, acc} <= {1'b0, acc} + {1'b0, alu_data};
                ALU_SUB:  {cy, acc} <= {1'b0, acc} - {1'b0, alu_data};
                ALU_ZERO: acc <= 8'h00;
                ALU_ONE:  acc <= 8'h01;
                ALU_XOR:  acc <= acc ^ alu_data;
                ALU_NOT:  acc <= ~acc;
                ALU_SHL:  {cy, acc} <= {acc, 1'b0};
                ALU_SHR:  acc <= {1'b0, acc[7:1]};
                default:  acc <= acc;
            endcase
        end
    end

    always_comb begin
        status         = '0;
        status[STAT_Z] = (acc == 8'h00);
        status[STAT_N] = acc[7];
        status[STAT_C] = cy;
    end

    assign alu_data_out = (prev_op == ALU_STATUS) ? status : acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input logic [3:0] addr, input logic [11:0] data);
        @(negedge clk);
        prog_we    = 1'b1;
        prog_addr  = addr;
        prog_wdata = data;
        @(negedge clk);
        prog_we    = 1'b0;
    endtask

    // Push expectation, start a run, track latency and optional mid-run disturbance.
    task automatic run(input string tag, input logic [7:0] exp_res, input logic exp_err,
                       input int exp_lat, input bit same_we, input logic [11:0] we0,
                       input bit inject);
        exp_t e;
        int   lat;
        sb.push_back('{exp_res, exp_err, exp_lat, tag});
        @(negedge clk);
        start = 1'b1;
        if (same_we) begin
            prog_we    = 1'b1;
            prog_addr  = 4'h0;
            prog_wdata = we0;
        end
        @(negedge clk);
        start   = 1'b0;
        prog_we = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        lat = 1;
        while (!done && lat < 400) begin
            if (inject && lat == 5) begin
                start      = 1'b1;
                prog_we    = 1'b1;
                prog_addr  = 4'h0;
                prog_wdata = 12'h177;
            end else begin
                start   = 1'b0;
                prog_we = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start   = 1'b0;
        prog_we = 1'b0;
        e = sb.pop_front();
        check({e.tag, "_done"}, 32'(done), 32'd1);
        check({e.tag, "_lat"}, 32'(lat), 32'(e.lat));
        check({e.tag, "_result"}, 32'(result), 32'(e.res));
        check({e.tag, "_err"}, 32'(err), 32'(e.err));
        @(negedge clk);
        check({e.tag, "_idle"}, 32'({busy, done}), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_opcode", 32'(alu_opcode), 32'd0);
        check("rst_data", 32'(alu_data), 32'd0);
        rst = 1'b0;

        write_word(4'h0, 12'h105);
        write_word(4'h1, 12'h203);
        write_word(4'h2, 12'hD00);
        run("t1_add", 8'h08, 1'b0, 4, 1'b0, 12'h0, 1'b0);

        write_word(4'h0, 12'h103);
        write_word(4'h1, 12'h301);
        write_word(4'h2, 12'hB01);
        write_word(4'h3, 12'hD00);
        run("t2_loop", 8'h00, 1'b0, 12, 1'b0, 12'h0, 1'b0);
        run("t5_inject", 8'h00, 1'b0, 12, 1'b0, 12'h0, 1'b1);
        run("t5_rerun", 8'h00, 1'b0, 12, 1'b0, 12'h0, 1'b0);

        write_word(4'h0, 12'h1FF);
        write_word(4'h1, 12'h201);
        write_word(4'h2, 12'hE04);
        write_word(4'h3, 12'h155);
        write_word(4'h4, 12'hD00);
        run("t3_carry", 8'h00, 1'b0, 6, 1'b0, 12'h0, 1'b0);

        write_word(4'h0, 12'hC00);
        run("t4_wdog", 8'h00, 1'b1, 256, 1'b0, 12'h0, 1'b0);
        check("t4_err_held", 32'(err), 32'd1);

        write_word(4'h0, 12'h105);
        write_word(4'h1, 12'h203);
        write_word(4'h2, 12'hD00);
        run("t4_clear", 8'h08, 1'b0, 4, 1'b0, 12'h0, 1'b0);
        check("t4_result_held", 32'(result), 32'h08);

        run("same_we", 8'h09, 1'b0, 4, 1'b1, 12'h106, 1'b0);

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("t6_opcode_live", 32'(alu_opcode), 32'(ALU_ADD));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        check("t6_opcode", 32'(alu_opcode), 32'd0);
        check("t6_result", 32'(result), 32'd0);
        run("t6_rerun", 8'h09, 1'b0, 4, 1'b0, 12'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
